// File: rtl/injection_pkg.sv
// -----------------------------------------------------------------------------
// injection_pkg
// Shared types and constants for the injection_monitor block.
//   state_t        per-channel FSM state (IDLE / ARM / ACTIVE), 2-bit encoding
//   hold_cnt_w()   width of the per-channel hold counter for a given HOLD
//   *_RST          reset values for the registered state
// -----------------------------------------------------------------------------
package injection_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam state_t ST_RST     = IDLE;
  localparam logic   STICKY_RST = 1'b0;

  // Counter must represent 0..HOLD, hence clog2(HOLD+1); never narrower than 1.
  function automatic int hold_cnt_w(input int hold);
    return (hold <= 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage : injection_pkg

// File: rtl/injection_channel.sv
// -----------------------------------------------------------------------------
// injection_channel
// One trigger-qualification channel: the output asserts only after the
// trigger has been sampled high on HOLD consecutive rising edges.
//
// Parameters
//   HOLD     consecutive trigger samples required before assert (>=1)
// Ports
//   clk      clock, rising edge
//   rst      synchronous, active-high reset
//   i_trig   combinational trigger condition for this channel
//   o_y      1 while the FSM is in ACTIVE (decoded from the state register)
//   o_evt    1 in the cycle whose rising edge moves the FSM into ACTIVE
// -----------------------------------------------------------------------------
module injection_channel
  import injection_pkg::*;
#(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_trig,
  output logic o_y,
  output logic o_evt
);

  localparam int CW = hold_cnt_w(HOLD);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (i_trig) begin
          if (HOLD == 1) begin
            w_state_nxt = ACTIVE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ARM;
            w_cnt_nxt   = CW'(1);
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      ARM: begin
        if (i_trig) begin
          // Compare one bit wider so cnt+1 cannot wrap before reaching HOLD.
          if ((CW+1)'(r_cnt) + (CW+1)'(1) == (CW+1)'(HOLD)) begin
            w_state_nxt = ACTIVE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          // Any gap breaks the streak; counting restarts from scratch.
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      ACTIVE: begin
        if (!i_trig) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode: y follows the registered state only; the event flags the
  // edge that will enter ACTIVE so the top can book it on that same edge.
  always_comb begin
    o_y   = (r_state == ACTIVE);
    o_evt = (w_state_nxt == ACTIVE) && (r_state != ACTIVE);
  end

endmodule : injection_channel

// File: rtl/injection_monitor.sv
// -----------------------------------------------------------------------------
// injection_monitor
// Multi-channel condition monitor. Each channel qualifies trig = (a|b)&c for
// HOLD consecutive cycles before asserting y. A sticky per-channel flag and a
// saturating global count of assert events expose both glitches and
// persistent faults.
//
// Build option: define FAULT_INJECT_EN to add inj_mask/inj_val, which
// override y combinationally per channel without disturbing the FSMs,
// sticky flags or event count.
//
// Parameters
//   NCH       number of channels (>=1)
//   HOLD      consecutive trigger cycles before assert (>=1)
//   EW        event counter width
// Ports
//   clk       clock, rising edge
//   rst       synchronous, active-high reset (priority over clr and trig)
//   a, b      per-channel OR terms
//   c         per-channel qualifier
//   clr       clear sticky flags and event count (same-cycle events survive)
//   y         per-channel asserted output
//   sticky    per-channel "has asserted since last clr/rst"
//   evt_cnt   saturating count of assert events
//   inj_mask  per-channel override enable   (FAULT_INJECT_EN only)
//   inj_val   per-channel override value    (FAULT_INJECT_EN only)
// -----------------------------------------------------------------------------
module injection_monitor
  import injection_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int HOLD = 1,
  parameter int EW   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] a,
  input  logic [NCH-1:0] b,
  input  logic [NCH-1:0] c,
  input  logic           clr,
  output logic [NCH-1:0] y,
  output logic [NCH-1:0] sticky,
  output logic [EW-1:0]  evt_cnt
`ifdef FAULT_INJECT_EN
  ,
  input  logic [NCH-1:0] inj_mask,
  input  logic [NCH-1:0] inj_val
`endif
);

  localparam int PW = $clog2(NCH + 1);
  localparam int SW = EW + PW + 1;
  localparam logic [EW-1:0] CNT_MAX = '1;

  logic [NCH-1:0] w_trig;
  logic [NCH-1:0] w_fsm_y;
  logic [NCH-1:0] w_evt;
  logic [PW-1:0]  w_pop;
  logic [SW-1:0]  w_sum;
  logic [EW-1:0]  w_cnt_nxt;
  logic [NCH-1:0] r_sticky;
  logic [EW-1:0]  r_evt_cnt;

  assign w_trig = (a | b) & c;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    injection_channel #(
      .HOLD (HOLD)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_trig (w_trig[g]),
      .o_y    (w_fsm_y[g]),
      .o_evt  (w_evt[g])
    );
  end

  // Popcount of this cycle's events, added to the count (or to zero on clr)
  // in a wider sum so saturation can be detected without wrap.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NCH; i++) begin
      w_pop = w_pop + PW'(w_evt[i]);
    end
    w_sum     = (clr ? '0 : SW'(r_evt_cnt)) + SW'(w_pop);
    w_cnt_nxt = (w_sum > SW'(CNT_MAX)) ? CNT_MAX : w_sum[EW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky  <= {NCH{STICKY_RST}};
      r_evt_cnt <= '0;
    end else begin
      // clr wipes old history but keeps events landing on the same edge.
      r_sticky  <= clr ? w_evt : (r_sticky | w_evt);
      r_evt_cnt <= w_cnt_nxt;
    end
  end

  assign sticky  = r_sticky;
  assign evt_cnt = r_evt_cnt;

`ifdef FAULT_INJECT_EN
  assign y = (w_fsm_y & ~inj_mask) | (inj_val & inj_mask);
`else
  assign y = w_fsm_y;
`endif

endmodule : injection_monitor
